seg7_scan_display: RTL and testbench
====================================

Name: seg7_scan_display

Overview:
- Parametrised multi-digit seven-segment driver.
- Accepts a binary value through a load handshake and converts it to BCD sequentially (shift-add-3, one bit per cycle).
- Holds the result and time-multiplexes N_DIGITS active-low digits onto one shared segment bus.
- Sits between game/score logic and the board's 7-seg pins; adds scanning, leading-zero blanking and overflow saturation to the single-digit decode.

Parameters:
- N_DIGITS, 4: number of digits scanned; legal range 1..8.
- BIN_W, 14: width of the binary input value.
- REFRESH_DIV, 100000: clock cycles each digit stays lit; legal range ≥2.
- BLANK_LZ, 1: 1 = blank leading zeros (digit 0 is never blanked); 0 = show all digits.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- value  in  BIN_W  binary number to display
- load  in  1  request to convert and display value
- busy  out  1  conversion in progress; load ignored while high
- ovf  out  1  last committed value exceeded 10^N_DIGITS-1
- seg  out  7  active-low segments, bit6=g .. bit0=a
- an  out  N_DIGITS  active-low digit enables; bit0 = least significant digit

Behaviour:
- Reset values, first edge with rst=1:
  - busy=0, ovf=0.
  - Display register = 0, digit index = 0, refresh counter = 0.
  - seg=7'b1000000 ("0").
  - an=all ones except bit0=0.
- Segment codes, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Blank = 1111111.
  - Any nibble 10..15 shows blank.
- Load handshake:
  - load sampled at edge t with busy=0 → value and overflow flag (value ≥ 10^N_DIGITS) are captured.
  - busy=1 for cycles t+1..t+BIN_W, with one shift-add-3 step per cycle.
  - At edge t+BIN_W+1: display register and ovf commit atomically, and busy=0.
  - load is accepted again that same cycle.
  - load while busy=1 is ignored; no queueing.
- Overflow: if the captured flag is set, the committed display is all 9s and ovf=1. Otherwise ovf=0.
- Conversion is not visible until commit. The display keeps the previous value throughout a conversion.
- Scanning:
  - The refresh counter runs 0..REFRESH_DIV-1.
  - On wrap, the digit index increments mod N_DIGITS (N_DIGITS-1 → 0).
  - Scanning is independent of load/busy.
- Outputs are registered:
  - seg/an reflect the digit index and display register with 1-cycle latency.
  - Exactly one an bit is low at any time after reset; never zero bits, never two.
- Blanking:
  - With BLANK_LZ=1, digit k>0 is blank when it and every more-significant digit are 0.
  - A blanked digit still gets its an bit low, and seg=1111111.
- Commit and scan on the same edge: the new seg uses the new index and the new display value.
- Reset mid-conversion: the conversion is aborted, busy=0, display=0, and pending data is discarded.
- rst has priority over load.

Decomposition:
- Package seg7_pkg:
  - SEG_* code constants for 0..9 and SEG_BLANK.
  - Function ceil_log2 for counter/index widths.
  - BCD nibble typedef.
- Sub-module seg7_decode: combinational nibble→seg using the package codes.
  - Instantiated once, after the digit mux.
- Double-dabble converter stays inline in the top module. It is a single FSM, IDLE → SHIFT → IDLE.

Test Plan (N_DIGITS=4, BIN_W=14, REFRESH_DIV=4, BLANK_LZ=1 unless stated):
- Reset: hold rst 2 cycles → busy=0, ovf=0, seg=1000000, an=1110. Over 16 cycles, an steps 1110, 1101, 1011, 0111, each digit 4 cycles; digits 1..3 show 1111111.
- load value=1234 at edge t → busy high t+1..t+14, low at t+15. Scan then shows digit0 0011001, digit1 0110000, digit2 0100100, digit3 1111001.
- load value=7, then value=0 → value 7: digit0 1111000, digits1–3 blank. value 0: digit0 1000000, others blank. Repeat 0 with BLANK_LZ=0 → all four digits show 1000000.
- load value=12345 → after commit ovf=1 and all digits show 0010000 (9). Then load 42 → ovf=0, digits show 2, 4, blank, blank.
- load 1234, then assert load with value=5678 at t+3 → second load ignored; display commits 1234; busy timing unchanged.
- load 1234, then after commit load 99, and assert rst at t+5 of the second conversion → next cycle busy=0, display 0. 99 never appears.

Source files
------------

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared segment codes, BCD types and sizing helpers
package seg7_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } conv_state_t;

  // Active-low, bit6 = g .. bit0 = a
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Never returns less than 1 so single-entry counters still get a real bit
  function automatic int ceil_log2(input int x);
    int r;
    r = 1;
    while ((1 << r) < x) r++;
    return r;
  endfunction

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational BCD nibble to active-low segment decode
module seg7_decode
  import seg7_pkg::*;
(
  input  bcd_t       nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_display.sv
// rtl/seg7_scan_display.sv - binary load, sequential double-dabble, scanned 7-seg output
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int BIN_W       = 14,
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_LZ    = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BIN_W-1:0]    value,
  input  logic                load,
  output logic                busy,
  output logic                ovf,
  output logic [6:0]          seg,
  output logic [N_DIGITS-1:0] an
);

  localparam int DW    = 4 * N_DIGITS;
  localparam int CNT_W = ceil_log2(BIN_W + 1);
  localparam int RC_W  = ceil_log2(REFRESH_DIV);
  localparam int IDX_W = ceil_log2(N_DIGITS);
  localparam logic [63:0]      LIMIT     = pow10(N_DIGITS);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BIN_W);
  localparam logic [RC_W-1:0]  RC_LAST   = RC_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIGITS - 1);

  conv_state_t      state, state_nxt;
  logic             start, commit;
  logic [BIN_W-1:0] bin_sr;
  logic [DW-1:0]    bcd_sr, bcd_adj, bcd_step;
  logic [CNT_W-1:0] step_cnt;
  logic             ovf_cap;
  logic [DW-1:0]    disp, disp_nxt;

  logic [RC_W-1:0]     rcnt, rcnt_nxt;
  logic [IDX_W-1:0]    idx, idx_nxt;
  logic [N_DIGITS-1:0] blank_vec, an_nxt;
  logic                zero_run, blank_sel;
  bcd_t                nibble;
  logic [6:0]          dec_seg;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (load) state_nxt = ST_SHIFT;
      ST_SHIFT: if (step_cnt == LAST_STEP) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy   = (state == ST_SHIFT);
    start  = (state == ST_IDLE) && load;
    commit = (state == ST_SHIFT) && (step_cnt == LAST_STEP);
  end

  // One add-3-then-shift step; high bits lost here only matter on overflow, which saturates
  always_comb begin
    bcd_adj = bcd_sr;
    for (int k = 0; k < N_DIGITS; k++)
      if (bcd_sr[k*4 +: 4] >= 4'd5) bcd_adj[k*4 +: 4] = bcd_sr[k*4 +: 4] + 4'd3;
    bcd_step = {bcd_adj[DW-2:0], bin_sr[BIN_W-1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_sr   <= '0;
      bcd_sr   <= '0;
      step_cnt <= '0;
      ovf_cap  <= 1'b0;
      ovf      <= 1'b0;
    end else if (start) begin
      bin_sr   <= value;
      bcd_sr   <= '0;
      step_cnt <= '0;
      ovf_cap  <= ({{(64 - BIN_W){1'b0}}, value} >= LIMIT);
    end else if (commit) begin
      ovf      <= ovf_cap;
    end else if (busy) begin
      bin_sr   <= bin_sr << 1;
      bcd_sr   <= bcd_step;
      step_cnt <= step_cnt + 1'b1;
    end
  end

  always_comb begin
    disp_nxt = disp;
    if (commit) disp_nxt = ovf_cap ? {N_DIGITS{4'd9}} : bcd_sr;
  end

  always_comb begin
    rcnt_nxt = rcnt + 1'b1;
    idx_nxt  = idx;
    if (rcnt == RC_LAST) begin
      rcnt_nxt = '0;
      idx_nxt  = (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end
  end

  // Segment/anode registers look at next-state index and display so a commit
  // coinciding with a scan step shows the new digit of the new value
  always_comb begin
    blank_vec = '0;
    zero_run  = 1'b1;
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      zero_run     = zero_run && (disp_nxt[k*4 +: 4] == 4'd0);
      blank_vec[k] = zero_run && (BLANK_LZ != 0);
    end
  end

  always_comb begin
    nibble    = 4'd0;
    blank_sel = 1'b0;
    an_nxt    = '1;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx_nxt == IDX_W'(k)) begin
        nibble    = disp_nxt[k*4 +: 4];
        blank_sel = blank_vec[k];
        an_nxt[k] = 1'b0;
      end
    end
  end

  seg7_decode u_decode (
    .nibble (nibble),
    .seg    (dec_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      disp <= '0;
      rcnt <= '0;
      idx  <= '0;
      seg  <= SEG_0;
      an   <= {{(N_DIGITS - 1){1'b1}}, 1'b0};
    end else begin
      disp <= disp_nxt;
      rcnt <= rcnt_nxt;
      idx  <= idx_nxt;
      seg  <= blank_sel ? SEG_BLANK : dec_seg;
      an   <= an_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_scan_display.sv
// tb/tb_seg7_scan_display.sv - table-driven scoreboard bench for seg7_scan_display
module tb_seg7_scan_display;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000, S9 = 7'b0010000, SB = 7'b1111111;

  typedef struct packed {
    logic [13:0]     value;
    logic            ovf;
    logic [3:0][6:0] segs;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, load;
  logic [13:0] value;
  logic        busy, ovf, busy_nz, ovf_nz;
  logic [6:0]  seg, seg_nz;
  logic [3:0]  an, an_nz;

  int   checks = 0;
  int   errors = 0;
  vec_t sb[$];
  vec_t cur;
  vec_t tbl[8];

  always #5 clk = ~clk;

  seg7_scan_display #(.N_DIGITS(4), .BIN_W(14), .REFRESH_DIV(4), .BLANK_LZ(1)) dut (
    .clk(clk), .rst(rst), .value(value), .load(load),
    .busy(busy), .ovf(ovf), .seg(seg), .an(an)
  );

  seg7_scan_display #(.N_DIGITS(4), .BIN_W(14), .REFRESH_DIV(4), .BLANK_LZ(0)) dut_nz (
    .clk(clk), .rst(rst), .value(value), .load(load),
    .busy(busy_nz), .ovf(ovf_nz), .seg(seg_nz), .an(an_nz)
  );

  function automatic vec_t mk(input logic [13:0] v, input logic o,
                              input logic [6:0] d3, input logic [6:0] d2,
                              input logic [6:0] d1, input logic [6:0] d0);
    vec_t r;
    r.value = v;
    r.ovf   = o;
    r.segs  = {d3, d2, d1, d0};
    return r;
  endfunction

  function automatic int an_idx(input logic [3:0] a);
    int n, idx;
    n = 0;
    idx = -1;
    for (int k = 0; k < 4; k++) if (a[k] === 1'b0) begin n++; idx = k; end
    return (n == 1) ? idx : -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 40) begin step(); n++; end
    chk("idle_wait", {31'd0, busy}, 32'd0);
  endtask

  // Load v at the next edge; intrude>0 drives a stray load sampled at edge t+intrude
  task automatic convert(input vec_t v, input int intrude);
    logic busy_ok, hold_ok;
    logic prev_ovf;
    int   i;
    vec_t e;
    wait_idle();
    prev_ovf = ovf;
    value = v.value;
    load  = 1'b1;
    sb.push_back(v);
    step();
    load    = 1'b0;
    busy_ok = (busy === 1'b1);
    hold_ok = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      if (k == intrude) begin value = 14'd5678; load = 1'b1; end
      step();
      load    = 1'b0;
      busy_ok = busy_ok && (busy === 1'b1);
      i       = an_idx(an);
      hold_ok = hold_ok && (ovf === prev_ovf) && (i >= 0) && (seg === cur.segs[i]);
    end
    chk("busy_window", {31'd0, busy_ok}, 32'd1);
    chk("display_hold", {31'd0, hold_ok}, 32'd1);
    step();
    chk("busy_release", {30'd0, busy, busy_nz}, 32'd0);
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("ovf", {31'd0, ovf}, {31'd0, e.ovf});
      chk("ovf_nz", {31'd0, ovf_nz}, {31'd0, e.ovf});
      cur = e;
    end
  endtask

  task automatic scan_check(input string name, input vec_t e, input logic use_nz);
    logic [3:0] visited;
    logic [3:0] a;
    logic [6:0] s;
    int         i;
    visited = 4'd0;
    for (int c = 0; c < 16; c++) begin
      a = use_nz ? an_nz : an;
      s = use_nz ? seg_nz : seg;
      i = an_idx(a);
      if (i < 0) begin
        chk({name, "_an_onehot"}, {28'd0, a}, 32'd0);
      end else begin
        visited[i] = 1'b1;
        chk({name, "_seg"}, {25'd0, s}, {25'd0, e.segs[i]});
      end
      step();
    end
    chk({name, "_visited"}, {28'd0, visited}, 32'hF);
  endtask

  initial begin
    logic ok;
    tbl[0] = mk(14'd1234,  1'b0, S1, S2, S3, S4);
    tbl[1] = mk(14'd7,     1'b0, SB, SB, SB, S7);
    tbl[2] = mk(14'd0,     1'b0, SB, SB, SB, S0);
    tbl[3] = mk(14'd12345, 1'b1, S9, S9, S9, S9);
    tbl[4] = mk(14'd42,    1'b0, SB, SB, S4, S2);
    tbl[5] = mk(14'd9999,  1'b0, S9, S9, S9, S9);
    tbl[6] = mk(14'd10000, 1'b1, S9, S9, S9, S9);
    tbl[7] = mk(14'd1005,  1'b0, S1, S0, S0, S5);

    rst = 1'b1; load = 1'b0; value = 14'd0;
    cur = mk(14'd0, 1'b0, SB, SB, SB, S0);
    @(negedge clk);
    step();
    step();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    rst = 1'b0;
    for (int c = 0; c < 16; c++) begin
      chk("rst_scan_an", {28'd0, an}, {28'd0, ~(4'd1 << (c / 4))});
      chk("rst_scan_seg", {25'd0, seg}, {25'd0, (c < 4) ? S0 : SB});
      chk("rst_scan_seg_nz", {25'd0, seg_nz}, {25'd0, S0});
      step();
    end

    for (int n = 0; n < 8; n++) begin
      convert(tbl[n], 0);
      scan_check("tbl", tbl[n], 1'b0);
    end

    // Back-to-back loads: the second is driven in the commit cycle itself
    convert(tbl[1], 0);
    convert(tbl[2], 0);
    scan_check("b2b_zero", tbl[2], 1'b0);
    scan_check("nolz_zero", mk(14'd0, 1'b0, S0, S0, S0, S0), 1'b1);

    convert(tbl[0], 3);
    scan_check("ignored_load", tbl[0], 1'b0);
    chk("no_queue_busy", {31'd0, busy}, 32'd0);

    wait_idle();
    value = 14'd99;
    load  = 1'b1;
    sb.push_back(mk(14'd99, 1'b0, SB, SB, S9, S9));
    step();
    load = 1'b0;
    for (int k = 0; k < 4; k++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb.delete();
    cur = mk(14'd0, 1'b0, SB, SB, SB, S0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_ovf", {31'd0, ovf}, 32'd0);
    chk("abort_an", {28'd0, an}, 32'hE);
    chk("abort_seg", {25'd0, seg}, {25'd0, S0});
    ok = 1'b1;
    for (int k = 0; k < 20; k++) begin step(); ok = ok && (busy === 1'b0); end
    chk("abort_stays_idle", {31'd0, ok}, 32'd1);
    scan_check("abort_display", cur, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
